// File: rtl/nw_seq_load_ctrl.sv
// -----------------------------------------------------------------------------
// nw_seq_load_ctrl
//
// Front-end sequencer for the Needleman-Wunsch core. After a start it takes a
// byte stream holding two newline-terminated DNA strings. It encodes each base
// to a 3-bit symbol and writes sequence A, then sequence B, into their
// sequence memories. It then fires a one-cycle launch pulse at the alignment
// core and waits for that core to finish. Bad characters, overflow and empty
// sequences are caught here, so the core only ever sees clean data.
//
// Ports
//   clk, rst        clock (rising edge) and synchronous active-high reset
//   start           begin a load (honoured only in IDLE, DONE, ERROR)
//   char_in/_valid  ASCII byte stream; char_ready high only while loading
//   wr_en_a/_b      one-cycle write strobes, valid the cycle after acceptance
//   wr_addr/wr_data shared write address and encoded symbol
//   len_a/len_b     lengths of the sequences loaded
//   align_start     one-cycle launch pulse; align_done ends the alignment
//   busy/done/error status decoded from the state register
//   err_code        0 none, 1 bad char, 2 overflow, 3 empty sequence
// -----------------------------------------------------------------------------
module nw_seq_load_ctrl #(
    parameter int          ADDR_W    = 7,
    parameter int          MAX_LEN   = 128,
    parameter logic [7:0]  TERM_CHAR = 8'h0A,
    parameter logic [7:0]  SKIP_CHAR = 8'h0D
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        char_in,
    input  logic              char_valid,
    output logic              char_ready,
    output logic              wr_en_a,
    output logic              wr_en_b,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [2:0]        wr_data,
    output logic [ADDR_W:0]   len_a,
    output logic [ADDR_W:0]   len_b,
    output logic              align_start,
    input  logic              align_done,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_LAUNCH,
        S_ALIGN,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W + 1)'(MAX_LEN);

    // Base characters in symbol order: entry i encodes to i+1 (G,T,A,C).
    localparam logic [7:0] SYM_CHAR [4] = '{8'h47, 8'h54, 8'h41, 8'h43};

    state_t              state_reg;
    logic [ADDR_W:0]     count_reg;
    logic [ADDR_W:0]     len_a_reg;
    logic [ADDR_W:0]     len_b_reg;
    logic                wr_en_a_reg;
    logic                wr_en_b_reg;
    logic [ADDR_W-1:0]   wr_addr_reg;
    logic [2:0]          wr_data_reg;
    logic [1:0]          err_code_reg;

    logic [3:0]          sym_hit;
    logic [2:0]          sym_code;
    logic                sym_valid;
    logic                is_term;
    logic                is_skip;
    logic                loading;
    logic                accept;

    // One comparator per base character.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sym_match
            assign sym_hit[gi] = (char_in == SYM_CHAR[gi]);
        end
    endgenerate

    always_comb begin
        sym_code = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (sym_hit[i]) begin
                sym_code = 3'(i + 1);
            end
        end
    end

    assign sym_valid = |sym_hit;
    assign is_term   = (char_in == TERM_CHAR);
    assign is_skip   = (char_in == SKIP_CHAR);
    assign loading   = (state_reg == S_LOAD_A) || (state_reg == S_LOAD_B);
    assign accept    = loading && char_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            count_reg    <= '0;
            len_a_reg    <= '0;
            len_b_reg    <= '0;
            wr_en_a_reg  <= 1'b0;
            wr_en_b_reg  <= 1'b0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
            err_code_reg <= '0;
        end else begin
            // Strobes are single-cycle; they are re-raised only on a write.
            wr_en_a_reg <= 1'b0;
            wr_en_b_reg <= 1'b0;

            case (state_reg)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        count_reg    <= '0;
                        len_a_reg    <= '0;
                        len_b_reg    <= '0;
                        err_code_reg <= 2'd0;
                        state_reg    <= S_LOAD_A;
                    end
                end

                S_LOAD_A, S_LOAD_B: begin
                    if (accept) begin
                        // The character classes are disjoint, so this chain
                        // also realises the error priority (bad, overflow,
                        // empty).
                        if (is_term) begin
                            if (count_reg == '0) begin
                                err_code_reg <= 2'd3;
                                state_reg    <= S_ERROR;
                            end else begin
                                count_reg <= '0;
                                if (state_reg == S_LOAD_A) begin
                                    len_a_reg <= count_reg;
                                    state_reg <= S_LOAD_B;
                                end else begin
                                    len_b_reg <= count_reg;
                                    state_reg <= S_LAUNCH;
                                end
                            end
                        end else if (is_skip) begin
                            // Carriage return: consumed, nothing written.
                        end else if (!sym_valid) begin
                            err_code_reg <= 2'd1;
                            state_reg    <= S_ERROR;
                        end else if (count_reg == MAX_CNT) begin
                            err_code_reg <= 2'd2;
                            state_reg    <= S_ERROR;
                        end else begin
                            wr_en_a_reg <= (state_reg == S_LOAD_A);
                            wr_en_b_reg <= (state_reg == S_LOAD_B);
                            wr_addr_reg <= count_reg[ADDR_W-1:0];
                            wr_data_reg <= sym_code;
                            count_reg   <= count_reg + 1'b1;
                        end
                    end
                end

                // align_done is not looked at here, so a pulse coinciding
                // with the launch cycle is ignored.
                S_LAUNCH: state_reg <= S_ALIGN;

                S_ALIGN: begin
                    if (align_done) begin
                        state_reg <= S_DONE;
                    end
                end

                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign char_ready  = loading;
    assign wr_en_a     = wr_en_a_reg;
    assign wr_en_b     = wr_en_b_reg;
    assign wr_addr     = wr_addr_reg;
    assign wr_data     = wr_data_reg;
    assign len_a       = len_a_reg;
    assign len_b       = len_b_reg;
    assign align_start = (state_reg == S_LAUNCH);
    assign busy        = loading || (state_reg == S_LAUNCH) || (state_reg == S_ALIGN);
    assign done        = (state_reg == S_DONE);
    assign error       = (state_reg == S_ERROR);
    assign err_code    = err_code_reg;

endmodule

// File: tb/tb_nw_seq_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nw_seq_load_ctrl
//
// Self-checking bench for nw_seq_load_ctrl. Each scenario streams a string,
// a string-level reference model predicts writes, lengths and error code, and
// the observed writes (captured by a monitor) are compared with it.
// -----------------------------------------------------------------------------
module tb_nw_seq_load_ctrl;

    localparam int ADDR_W  = 7;
    localparam int MAX_LEN = 128;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [7:0]        char_in;
    logic              char_valid;
    logic              char_ready;
    logic              wr_en_a;
    logic              wr_en_b;
    logic [ADDR_W-1:0] wr_addr;
    logic [2:0]        wr_data;
    logic [ADDR_W:0]   len_a;
    logic [ADDR_W:0]   len_b;
    logic              align_start;
    logic              align_done;
    logic              busy;
    logic              done;
    logic              error;
    logic [1:0]        err_code;

    int checks   = 0;
    int failures = 0;

    nw_seq_load_ctrl #(
        .ADDR_W    (ADDR_W),
        .MAX_LEN   (MAX_LEN),
        .TERM_CHAR (8'h0A),
        .SKIP_CHAR (8'h0D)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .char_in     (char_in),
        .char_valid  (char_valid),
        .char_ready  (char_ready),
        .wr_en_a     (wr_en_a),
        .wr_en_b     (wr_en_b),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .len_a       (len_a),
        .len_b       (len_b),
        .align_start (align_start),
        .align_done  (align_done),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .err_code    (err_code)
    );

    always #5 clk = ~clk;

    // Monitor: every observed write, encoded as addr*8 + symbol.
    int got_a[$];
    int got_b[$];
    int n_launch = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en_a) got_a.push_back(int'(wr_addr) * 8 + int'(wr_data));
            if (wr_en_b) got_b.push_back(int'(wr_addr) * 8 + int'(wr_data));
            if (align_start) n_launch++;
        end
    end

    // Reference model results.
    int exp_a[$];
    int exp_b[$];
    int exp_len_a;
    int exp_len_b;
    int exp_err;
    int exp_used;
    bit exp_ok;

    function automatic int base_code(input byte c);
        case (c)
            "G":     return 1;
            "T":     return 2;
            "A":     return 3;
            "C":     return 4;
            default: return 0;
        endcase
    endfunction

    // Walks the string as the loader should: returns the expected writes per
    // sequence, the lengths, the error code, and how many bytes get consumed.
    task automatic model(input string s);
        int seq_idx = 0;
        int n = 0;
        exp_a.delete();
        exp_b.delete();
        exp_len_a = 0;
        exp_len_b = 0;
        exp_err   = 0;
        exp_used  = 0;
        for (int i = 0; i < s.len(); i++) begin
            byte c;
            if (seq_idx == 2) break;
            c = s[i];
            exp_used = i + 1;
            if (c == 8'h0A) begin
                if (n == 0) begin
                    exp_err = 3;
                    break;
                end
                if (seq_idx == 0) exp_len_a = n;
                else              exp_len_b = n;
                n = 0;
                seq_idx++;
            end else if (c == 8'h0D) begin
                // discarded
            end else if (base_code(c) == 0) begin
                exp_err = 1;
                break;
            end else if (n == MAX_LEN) begin
                exp_err = 2;
                break;
            end else begin
                if (seq_idx == 0) exp_a.push_back(n * 8 + base_code(c));
                else              exp_b.push_back(n * 8 + base_code(c));
                n++;
            end
        end
        exp_ok = (seq_idx == 2) && (exp_err == 0);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic begin_load(input string name);
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (char_ready !== 1'b1 || error !== 1'b0 || err_code !== 2'd0 ||
            done !== 1'b0 || busy !== 1'b1 || len_a !== '0 || len_b !== '0) begin
            failures++;
            $display("FAIL %s start_clear: ready=%b err=%b code=%0d done=%b busy=%b la=%0d lb=%0d, required ready=1 err=0 code=0 done=0 busy=1 la=0 lb=0",
                     name, char_ready, error, err_code, done, busy, len_a, len_b);
        end
    endtask

    // Presents one byte (after optional random idle gaps) and returns on the
    // falling edge following its acceptance. Returns 0 on timeout.
    task automatic send_char(input byte c, input int gap_pct, output bit ok);
        int t = 0;
        int g = 0;
        while ($urandom_range(0, 99) < gap_pct && g < 4) begin
            char_valid = 1'b0;
            char_in    = 8'($urandom);
            tick();
            g++;
        end
        char_in    = c;
        char_valid = 1'b1;
        while (char_ready !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        ok = (t < 50);
        if (ok) tick();
        char_valid = 1'b0;
    endtask

    task automatic compare_writes(input string name, input int base_a, input int base_b);
        checks++;
        if (got_a.size() - base_a != exp_a.size()) begin
            failures++;
            $display("FAIL %s count_a: got %0d writes, required %0d", name, got_a.size() - base_a, exp_a.size());
        end else begin
            for (int k = 0; k < exp_a.size(); k++) begin
                checks++;
                if (got_a[base_a + k] !== exp_a[k]) begin
                    failures++;
                    $display("FAIL %s write_a[%0d]: addr/sym %0d/%0d, required %0d/%0d", name, k,
                             got_a[base_a + k] / 8, got_a[base_a + k] % 8, exp_a[k] / 8, exp_a[k] % 8);
                end
            end
        end
        checks++;
        if (got_b.size() - base_b != exp_b.size()) begin
            failures++;
            $display("FAIL %s count_b: got %0d writes, required %0d", name, got_b.size() - base_b, exp_b.size());
        end else begin
            for (int k = 0; k < exp_b.size(); k++) begin
                checks++;
                if (got_b[base_b + k] !== exp_b[k]) begin
                    failures++;
                    $display("FAIL %s write_b[%0d]: addr/sym %0d/%0d, required %0d/%0d", name, k,
                             got_b[base_b + k] / 8, got_b[base_b + k] % 8, exp_b[k] / 8, exp_b[k] % 8);
                end
            end
        end
    endtask

    // Full load: stream s, optionally pulse start (ignored) before byte
    // start_at, then finish the alignment or inspect the error state.
    task automatic run_case(input string name, input string s, input int gap_pct, input int start_at);
        int base_a;
        int base_b;
        int base_l;
        bit ok = 1'b1;
        begin_load(name);
        base_a = got_a.size();
        base_b = got_b.size();
        base_l = n_launch;
        model(s);
        for (int i = 0; i < exp_used; i++) begin
            if (i == start_at) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            send_char(s[i], gap_pct, ok);
            if (!ok) break;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s accept_timeout: char_ready stayed %b, required 1", name, char_ready);
            return;
        end
        if (exp_err != 0) begin
            checks++;
            if (error !== 1'b1 || err_code !== 2'(exp_err) || char_ready !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL %s error_state: err=%b code=%0d ready=%b busy=%b, required err=1 code=%0d ready=0 busy=0",
                         name, error, err_code, char_ready, busy, exp_err);
            end
            // Keep offering bytes: nothing may be accepted or written.
            char_valid = 1'b1;
            char_in    = "G";
            repeat (3) tick();
            char_valid = 1'b0;
            checks++;
            if (error !== 1'b1 || err_code !== 2'(exp_err) || n_launch != base_l) begin
                failures++;
                $display("FAIL %s error_hold: err=%b code=%0d launches=%0d, required err=1 code=%0d launches=0",
                         name, error, err_code, n_launch - base_l, exp_err);
            end
        end else begin
            // The falling edge right after the final newline is the launch cycle.
            checks++;
            if (align_start !== 1'b1 || busy !== 1'b1) begin
                failures++;
                $display("FAIL %s launch: align_start=%b busy=%b, required 1 1", name, align_start, busy);
            end
            align_done = $urandom_range(0, 1) == 1;
            tick();
            align_done = 1'b0;
            start      = 1'b1;
            tick();
            start      = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
            checks++;
            if (align_start !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL %s align_wait: align_start=%b busy=%b done=%b, required 0 1 0", name, align_start, busy, done);
            end
            align_done = 1'b1;
            tick();
            align_done = 1'b0;
            checks++;
            if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0 || n_launch - base_l != 1) begin
                failures++;
                $display("FAIL %s done: done=%b busy=%b err=%b launches=%0d, required 1 0 0 1",
                         name, done, busy, error, n_launch - base_l);
            end
        end
        checks++;
        if (int'(len_a) != exp_len_a || int'(len_b) != exp_len_b) begin
            failures++;
            $display("FAIL %s lengths: len_a=%0d len_b=%0d, required %0d %0d", name, len_a, len_b, exp_len_a, exp_len_b);
        end
        compare_writes(name, base_a, base_b);
        $display("case %s: used=%0d err=%0d len_a=%0d len_b=%0d", name, exp_used, exp_err, exp_len_a, exp_len_b);
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({char_ready, wr_en_a, wr_en_b, wr_addr, wr_data, len_a, len_b,
             align_start, busy, done, error, err_code} !== '0) begin
            failures++;
            $display("FAIL %s outputs_zero: ready=%b wa=%b wb=%b addr=%0d data=%0d la=%0d lb=%0d as=%b busy=%b done=%b err=%b code=%0d, required all 0",
                     name, char_ready, wr_en_a, wr_en_b, wr_addr, wr_data, len_a, len_b,
                     align_start, busy, done, error, err_code);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();
        check_all_zero("idle_after_reset");
        $display("case reset");
    endtask

    task automatic test_basic();
        run_case("basic", "GATC\nTTG\n", 0, -1);
    endtask

    task automatic test_skip_char();
        run_case("cr_skip", "GA\r\nC\n", 0, -1);
    endtask

    task automatic test_bad_char();
        run_case("bad_char", "GAXC\n", 0, -1);
    endtask

    task automatic test_overflow();
        string s = "";
        for (int i = 0; i < MAX_LEN; i++) s = {s, "A"};
        run_case("overflow", {s, "A"}, 0, -1);
        run_case("max_len", {s, "\nG\n"}, 10, -1);
    endtask

    task automatic test_empty();
        run_case("empty_a", "\n", 0, -1);
        run_case("empty_b", "GA\n\n", 0, -1);
    endtask

    task automatic test_start_ignored();
        run_case("start_busy", "GAT\nC\n", 30, 2);
    endtask

    task automatic test_reset_mid();
        bit ok;
        string s = "GA\nT";
        begin_load("rst_load_b");
        for (int i = 0; i < s.len(); i++) send_char(s[i], 0, ok);
        rst = 1'b1;
        tick();
        check_all_zero("rst_load_b");
        rst = 1'b0;
        s = "GT\nA\n";
        begin_load("rst_align");
        for (int i = 0; i < s.len(); i++) send_char(s[i], 0, ok);
        tick();
        tick();
        checks++;
        if (busy !== 1'b1 || len_a !== 8'd2 || len_b !== 8'd1) begin
            failures++;
            $display("FAIL rst_align pre: busy=%b la=%0d lb=%0d, required 1 2 1", busy, len_a, len_b);
        end
        rst = 1'b1;
        tick();
        check_all_zero("rst_align");
        rst = 1'b0;
        tick();
        check_all_zero("rst_align_idle");
        $display("case reset_mid");
    endtask

    task automatic test_random();
        string bases = "GTAC";
        for (int n = 0; n < 25; n++) begin
            string s = "";
            for (int part = 0; part < 2; part++) begin
                int plen = $urandom_range(0, 7);
                for (int k = 0; k < plen; k++) begin
                    int r = $urandom_range(0, 39);
                    byte c;
                    if (r < 36)      c = bases[r % 4];
                    else if (r < 38) c = 8'h0D;
                    else if (r < 39) c = "x";
                    else             c = "N";
                    s = $sformatf("%s%c", s, c);
                end
                s = {s, "\n"};
            end
            run_case($sformatf("rand%0d", n), s, $urandom_range(0, 60), $urandom_range(0, 12));
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        char_in    = 8'h00;
        char_valid = 1'b0;
        align_done = 1'b0;
        tick();
        test_reset();
        test_basic();
        test_skip_char();
        test_bad_char();
        test_overflow();
        test_empty();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
